// File: rtl/coord_bank_writer.sv
// coord_bank_writer: write side of the sprite coordinate path.
// Coordinate writes land in per-slot shadow registers via a valid/ready
// handshake. On each frame boundary the pending shadows are copied into the
// active (x,y) pairs that feed the coordinate mux, so sprites never tear
// mid-frame.
// Optional build macro: COORD_CLAMP_EN clamps accepted coordinates to
// X_MAX / Y_MAX. When it is undefined, values are stored verbatim.
//
// state  | meaning
// IDLE   | ready for a write unless a commit is requested
// ACK    | one-cycle handshake recovery after an accept
// COMMIT | copy pending shadows to the active pairs
module coord_bank_writer #(
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [1:0]  wr_slot,
    input  logic [10:0] wr_x,
    input  logic [9:0]  wr_y,
    input  logic        frame_start,
    output logic [10:0] x1,
    output logic [10:0] x2,
    output logic [10:0] x3,
    output logic [10:0] x4,
    output logic [9:0]  y1,
    output logic [9:0]  y2,
    output logic [9:0]  y3,
    output logic [9:0]  y4,
    output logic [3:0]  pending,
    output logic        commit_done
);

    typedef enum logic [1:0] {IDLE, ACK, COMMIT} state_t;

    state_t            state_q, state_d;
    logic              wr_ready_q, wr_ready_d;
    logic              commit_req_q, commit_req_d;
    logic              commit_done_q, commit_done_d;
    logic [3:0]        pending_q, pending_d;
    logic [3:0][10:0]  sh_x_q, sh_x_d, act_x_q, act_x_d;
    logic [3:0][9:0]   sh_y_q, sh_y_d, act_y_q, act_y_d;
    logic [10:0]       x_in;
    logic [9:0]        y_in;

    // Value that gets stored on accept (clamped when the feature is built in).
    always_comb begin
`ifdef COORD_CLAMP_EN
        x_in = (wr_x > 11'(X_MAX)) ? 11'(X_MAX) : wr_x;
        y_in = (wr_y > 10'(Y_MAX)) ? 10'(Y_MAX) : wr_y;
`else
        x_in = wr_x;
        y_in = wr_y;
`endif
    end

    // Next-state, shadow/active update and handshake logic.
    always_comb begin
        state_d       = state_q;
        commit_req_d  = commit_req_q;
        commit_done_d = 1'b0;
        pending_d     = pending_q;
        sh_x_d        = sh_x_q;
        sh_y_d        = sh_y_q;
        act_x_d       = act_x_q;
        act_y_d       = act_y_q;
        case (state_q)
            IDLE: begin
                if (commit_req_q) begin
                    state_d = COMMIT;
                end else if (wr_valid && wr_ready_q) begin
                    sh_x_d[wr_slot]    = x_in;
                    sh_y_d[wr_slot]    = y_in;
                    pending_d[wr_slot] = 1'b1;
                    state_d            = ACK;
                end
            end
            // A frame_start that coincided with the accept goes straight to
            // COMMIT, giving the 3-edge minimum accept-to-visible latency.
            ACK: state_d = commit_req_q ? COMMIT : IDLE;
            COMMIT: begin
                for (int i = 0; i < 4; i++) begin
                    if (pending_q[i]) begin
                        act_x_d[i] = sh_x_q[i];
                        act_y_d[i] = sh_y_q[i];
                    end
                end
                pending_d     = '0;
                commit_req_d  = 1'b0;
                commit_done_d = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A new frame boundary always wins over the clear in COMMIT.
        if (frame_start) commit_req_d = 1'b1;
        wr_ready_d = (state_d == IDLE) && !commit_req_d;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            wr_ready_q    <= 1'b0;
            commit_req_q  <= 1'b0;
            commit_done_q <= 1'b0;
            pending_q     <= '0;
            sh_x_q        <= '0;
            sh_y_q        <= '0;
            act_x_q       <= '0;
            act_y_q       <= '0;
        end else begin
            state_q       <= state_d;
            wr_ready_q    <= wr_ready_d;
            commit_req_q  <= commit_req_d;
            commit_done_q <= commit_done_d;
            pending_q     <= pending_d;
            sh_x_q        <= sh_x_d;
            sh_y_q        <= sh_y_d;
            act_x_q       <= act_x_d;
            act_y_q       <= act_y_d;
        end
    end

    assign wr_ready    = wr_ready_q;
    assign commit_done = commit_done_q;
    assign pending     = pending_q;
    assign x1 = act_x_q[0];
    assign x2 = act_x_q[1];
    assign x3 = act_x_q[2];
    assign x4 = act_x_q[3];
    assign y1 = act_y_q[0];
    assign y2 = act_y_q[1];
    assign y3 = act_y_q[2];
    assign y4 = act_y_q[3];

endmodule
